branch_sequencer: RTL and testbench
===================================

# branch_sequencer

Control-step sequencer for conditional-branch instructions in the Mini SRC CPU. It walks the fetch steps T0–T2 and the branch execute steps T3–T6. It drives the bus, register, ALU and memory strobes, and asserts `CONin` so the CON flip-flop evaluates Ra against IR[20:19]. In T6 it loads the branch target into PC only if the registered CON value is 1. It sits between the memory interface and the datapath, and counts executed and taken branches for debug.

## Interface
- `BR_OPCODE`, default 5'b10010: IR[31:27] value that identifies a branch.
- `CNT_W`, default 16: width of the branch statistics counters.

- `clk`, input, 1: system clock, rising edge.
- `clr`, input, 1: reset, asynchronous, active-high.
- `run`, input, 1: level; while high, the sequencer fetches and executes instructions.
- `mem_ready`, input, 1: memory has valid read data this cycle.
- `opcode`, input, 5: IR[31:27], valid from the cycle after T2.
- `con`, input, 1: registered CON flip-flop output.
- `PCout`, `MARin`, `IncPC`, `Zin`, `Zlowout`, `PCin`, `Read`, `MDRin`, `MDRout`, `IRin`, `Gra`, `Rout`, `CONin`, `Yin`, `Cout`, `ADD`: each output, 1, a datapath strobe.
- `busy`, output, 1: high in every state except IDLE and HALT.
- `illegal`, output, 1: sticky; set when a non-branch opcode is decoded.
- `br_count`, output, `CNT_W`: branches completed.
- `br_taken`, output, `CNT_W`: branches that loaded PC.

## Operation
- States: IDLE, T0, T1, T2, T3, T4, T5, T6, HALT. Reset state is IDLE.
- IDLE: goes to T0 when `run`=1.
- T0: asserts `PCout`, `MARin`, `IncPC`, `Zin`. Goes to T1.
- T1: asserts `Zlowout`, `Read`, `MDRin`. Stays in T1 while `mem_ready`=0. Pulses `PCin` only in the cycle where `mem_ready`=1, then goes to T2.
- T2: asserts `MDRout`, `IRin`. Goes to T3.
- T3: if `opcode`!=`BR_OPCODE`, sets `illegal` and goes to HALT with no strobes asserted. Otherwise asserts `Gra`, `Rout`, `CONin` and goes to T4.
- T4: asserts `PCout`, `Yin`. Goes to T5.
- T5: asserts `Cout`, `ADD`, `Zin`. Goes to T6.
- T6: asserts `Zlowout`. Asserts `PCin` = `con` (Mealy term). Increments `br_count`. Increments `br_taken` if `con`=1. Goes to T0 if `run`=1, else IDLE.
- HALT: absorbing state; only `clr` exits it.
- `run` falling mid-instruction is ignored; the instruction always completes through T6.
- Strobe outputs are decoded combinationally from the state. Every strobe not listed for a state is 0.
- Counters wrap modulo 2^`CNT_W` with no saturation.
- Reset values: state IDLE, all strobes 0, `busy`=0, `illegal`=0, both counters 0.

## Timing
- One state per clock, except T1 memory wait states.
- Minimum instruction time is 7 cycles, T0 through T6, with `mem_ready` already high in T1.
- CON updates on the T3→T4 edge, so `con` is stable in T6. It is sampled combinationally in T6.
- `PCin` appears twice per instruction: in T1 it loads PC+4, in T6 it loads PC+4+C when taken.
- `clr` asserted in any state forces IDLE and clears all outputs asynchronously. Any in-flight memory read is abandoned.

## Structure
- Shared package `src_ctrl_pkg`:
  - state enum encodings IDLE..HALT;
  - `BR_OPCODE` default;
  - C2 condition encodings: 00 brzr, 01 brnz, 10 brpl, 11 brmi.
- Sub-module `br_stat_counters` holds the two `CNT_W` counters. Its inputs are an increment enable and a taken flag.
- Everything else stays in one FSM module: a next-state block and an output decode block.

## Test plan
- Reset: assert `clr` mid-T4 → state IDLE, all strobes 0, `br_count`=0, `br_taken`=0.
- Taken brzr: Ra=0, C2=00, `mem_ready` tied 1, `run`=1 → 7 cycles T0..T6, `PCin`=1 in T6, `br_taken`=1, `br_count`=1.
- Not-taken brpl: Ra=0x8000_0000, C2=10 → `PCin`=0 in T6, `br_count`=1, `br_taken`=0.
- Memory wait: `mem_ready` low for 3 cycles in T1 → `Read` and `MDRin` held for 4 cycles, `PCin` pulses once on the ready cycle, total 10 cycles.
- Illegal opcode: IR opcode 5'b00011 → `illegal`=1, state HALT, `busy`=0. `run` toggling has no effect until `clr`.
- Wrap: `CNT_W`=4, 16 taken brnz with Ra=1 → `br_count`=0 and `br_taken`=0 after wrap. `run` dropped during T2 → instruction completes, then IDLE.

Source files
------------

// File: rtl/src_ctrl_pkg.sv
// Shared control-step definitions for the Mini SRC control unit:
// state encodings, default branch opcode, C2 condition codes, strobe bundle.
package src_ctrl_pkg;

  typedef enum logic [3:0] {
    S_IDLE = 4'd0,
    S_T0   = 4'd1,
    S_T1   = 4'd2,
    S_T2   = 4'd3,
    S_T3   = 4'd4,
    S_T4   = 4'd5,
    S_T5   = 4'd6,
    S_T6   = 4'd7,
    S_HALT = 4'd8
  } state_e;

  localparam logic [4:0] BR_OPCODE_DEF = 5'b10010;

  // IR[20:19] condition field evaluated by the CON flip-flop
  typedef enum logic [1:0] {
    C2_BRZR = 2'b00,
    C2_BRNZ = 2'b01,
    C2_BRPL = 2'b10,
    C2_BRMI = 2'b11
  } c2_e;

  typedef struct packed {
    logic pc_out;
    logic mar_in;
    logic inc_pc;
    logic z_in;
    logic zlow_out;
    logic pc_in;
    logic read;
    logic mdr_in;
    logic mdr_out;
    logic ir_in;
    logic gra;
    logic r_out;
    logic con_in;
    logic y_in;
    logic c_out;
    logic add;
  } strobe_t;

endpackage

// File: rtl/br_stat_counters.sv
// Debug counters for executed and taken branches; both wrap freely.
module br_stat_counters #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             inc_en,
  input  logic             taken,
  output logic [CNT_W-1:0] br_count,
  output logic [CNT_W-1:0] br_taken
);

  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] taken_q, taken_d;

  always_comb begin
    count_d = count_q;
    taken_d = taken_q;
    if (inc_en) begin
      count_d = count_q + CNT_W'(1);
      if (taken) taken_d = taken_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      count_q <= '0;
      taken_q <= '0;
    end else begin
      count_q <= count_d;
      taken_q <= taken_d;
    end
  end

  assign br_count = count_q;
  assign br_taken = taken_q;

endmodule

// File: rtl/branch_sequencer.sv
// Fetch (T0-T2) and conditional-branch execute (T3-T6) control sequencer.
// Strobes are decoded from the state; PCin also depends on mem_ready/con.
module branch_sequencer
  import src_ctrl_pkg::*;
#(
  parameter logic [4:0] BR_OPCODE = BR_OPCODE_DEF,
  parameter int         CNT_W     = 16
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             run,
  input  logic             mem_ready,
  input  logic [4:0]       opcode,
  input  logic             con,
  output logic             PCout,
  output logic             MARin,
  output logic             IncPC,
  output logic             Zin,
  output logic             Zlowout,
  output logic             PCin,
  output logic             Read,
  output logic             MDRin,
  output logic             MDRout,
  output logic             IRin,
  output logic             Gra,
  output logic             Rout,
  output logic             CONin,
  output logic             Yin,
  output logic             Cout,
  output logic             ADD,
  output logic             busy,
  output logic             illegal,
  output logic [CNT_W-1:0] br_count,
  output logic [CNT_W-1:0] br_taken
);

  state_e  state_q, state_d;
  logic    illegal_q, illegal_d;
  logic    is_branch;
  strobe_t st;

  assign is_branch = (opcode == BR_OPCODE);

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q   <= S_IDLE;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
    end
  end

  // Next state; run is only consulted at instruction boundaries.
  always_comb begin
    state_d   = state_q;
    illegal_d = illegal_q;
    case (state_q)
      S_IDLE: if (run) state_d = S_T0;
      S_T0:   state_d = S_T1;
      S_T1:   if (mem_ready) state_d = S_T2;
      S_T2:   state_d = S_T3;
      S_T3: begin
        if (is_branch) begin
          state_d = S_T4;
        end else begin
          state_d   = S_HALT;
          illegal_d = 1'b1;
        end
      end
      S_T4:   state_d = S_T5;
      S_T5:   state_d = S_T6;
      S_T6:   state_d = run ? S_T0 : S_IDLE;
      S_HALT: state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    st = '0;
    case (state_q)
      S_T0: begin
        st.pc_out = 1'b1;
        st.mar_in = 1'b1;
        st.inc_pc = 1'b1;
        st.z_in   = 1'b1;
      end
      S_T1: begin
        st.zlow_out = 1'b1;
        st.read     = 1'b1;
        st.mdr_in   = 1'b1;
        st.pc_in    = mem_ready;
      end
      S_T2: begin
        st.mdr_out = 1'b1;
        st.ir_in   = 1'b1;
      end
      S_T3: begin
        st.gra    = is_branch;
        st.r_out  = is_branch;
        st.con_in = is_branch;
      end
      S_T4: begin
        st.pc_out = 1'b1;
        st.y_in   = 1'b1;
      end
      S_T5: begin
        st.c_out = 1'b1;
        st.add   = 1'b1;
        st.z_in  = 1'b1;
      end
      S_T6: begin
        st.zlow_out = 1'b1;
        st.pc_in    = con;
      end
      default: st = '0;
    endcase
  end

  assign PCout   = st.pc_out;
  assign MARin   = st.mar_in;
  assign IncPC   = st.inc_pc;
  assign Zin     = st.z_in;
  assign Zlowout = st.zlow_out;
  assign PCin    = st.pc_in;
  assign Read    = st.read;
  assign MDRin   = st.mdr_in;
  assign MDRout  = st.mdr_out;
  assign IRin    = st.ir_in;
  assign Gra     = st.gra;
  assign Rout    = st.r_out;
  assign CONin   = st.con_in;
  assign Yin     = st.y_in;
  assign Cout    = st.c_out;
  assign ADD     = st.add;

  assign busy    = (state_q != S_IDLE) && (state_q != S_HALT);
  assign illegal = illegal_q;

  br_stat_counters #(.CNT_W(CNT_W)) u_stat (
    .clk      (clk),
    .clr      (clr),
    .inc_en   (state_q == S_T6),
    .taken    (con),
    .br_count (br_count),
    .br_taken (br_taken)
  );

endmodule

// File: tb/tb_branch_sequencer.sv
// Instruction-level bench: each instruction is expanded into its expected
// per-cycle strobe timeline and checked every cycle on the falling edge.
module tb_branch_sequencer;

  localparam int         CNT_W = 4;
  localparam logic [4:0] BR_OP = 5'b10010;
  localparam int         CMASK = (1 << CNT_W) - 1;

  // Expected strobe words, order {PCout,MARin,IncPC,Zin,Zlowout,PCin,Read,
  // MDRin,MDRout,IRin,Gra,Rout,CONin,Yin,Cout,ADD}
  localparam logic [15:0] E_T0   = 16'hF000;
  localparam logic [15:0] E_T1   = 16'h0B00;
  localparam logic [15:0] E_PCIN = 16'h0400;
  localparam logic [15:0] E_T2   = 16'h00C0;
  localparam logic [15:0] E_T3   = 16'h0038;
  localparam logic [15:0] E_T4   = 16'h8004;
  localparam logic [15:0] E_T5   = 16'h1003;
  localparam logic [15:0] E_T6   = 16'h0800;

  logic clk = 1'b0;
  logic clr, run, mem_ready, con;
  logic [4:0] opcode;
  logic PCout, MARin, IncPC, Zin, Zlowout, PCin, Read, MDRin, MDRout, IRin;
  logic Gra, Rout, CONin, Yin, Cout, ADD, busy, illegal;
  logic [CNT_W-1:0] br_count, br_taken;

  branch_sequencer #(.BR_OPCODE(BR_OP), .CNT_W(CNT_W)) dut (
    .clk(clk), .clr(clr), .run(run), .mem_ready(mem_ready), .opcode(opcode),
    .con(con), .PCout(PCout), .MARin(MARin), .IncPC(IncPC), .Zin(Zin),
    .Zlowout(Zlowout), .PCin(PCin), .Read(Read), .MDRin(MDRin),
    .MDRout(MDRout), .IRin(IRin), .Gra(Gra), .Rout(Rout), .CONin(CONin),
    .Yin(Yin), .Cout(Cout), .ADD(ADD), .busy(busy), .illegal(illegal),
    .br_count(br_count), .br_taken(br_taken)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;
  bit chk_en = 1'b0;
  logic [15:0] exp_str;
  bit exp_busy, exp_ill;
  int m_cnt, m_tk;
  int busy_cycles, read_cycles, pcin_cycles;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // CON flip-flop rule from Ra and C2
  function automatic logic cond(input logic [31:0] ra, input logic [1:0] c2);
    case (c2)
      2'b00:   return ra == 32'd0;
      2'b01:   return ra != 32'd0;
      2'b10:   return ra[31] == 1'b0;
      default: return ra[31] == 1'b1;
    endcase
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      chk("strobes", {16'd0, PCout, MARin, IncPC, Zin, Zlowout, PCin, Read, MDRin,
                      MDRout, IRin, Gra, Rout, CONin, Yin, Cout, ADD}, {16'd0, exp_str});
      chk("busy", {31'd0, busy}, {31'd0, exp_busy});
      chk("illegal", {31'd0, illegal}, {31'd0, exp_ill});
      chk("br_count", {{(32-CNT_W){1'b0}}, br_count}, m_cnt);
      chk("br_taken", {{(32-CNT_W){1'b0}}, br_taken}, m_tk);
      busy_cycles += int'(busy);
      read_cycles += int'(Read);
      pcin_cycles += int'(PCin);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic step(input logic [15:0] v, input bit b);
    exp_str  = v;
    exp_busy = b;
    chk_en   = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_stats();
    busy_cycles = 0; read_cycles = 0; pcin_cycles = 0;
  endtask

  task automatic do_clr();
    clr = 1'b1; m_cnt = 0; m_tk = 0; exp_ill = 1'b0;
    step(16'h0, 1'b0);
    clr = 1'b0;
  endtask

  // One instruction from T0; caller has already spent the IDLE->T0 cycle
  // (or the previous T6 had run=1).
  task automatic do_instr(input int waits, input logic [4:0] op, input logic [31:0] ra,
                          input logic [1:0] c2, input bit run_t6, input bit drop_t2,
                          input bit clr_t4);
    logic c;
    c = cond(ra, c2);
    run = 1'($urandom); mem_ready = 1'($urandom); con = 1'($urandom);
    opcode = 5'($urandom);
    step(E_T0, 1'b1);
    for (int i = 0; i < waits; i++) begin
      mem_ready = 1'b0; con = 1'($urandom); run = 1'($urandom);
      step(E_T1, 1'b1);
    end
    mem_ready = 1'b1;
    step(E_T1 | E_PCIN, 1'b1);
    mem_ready = 1'($urandom); run = drop_t2 ? 1'b0 : 1'($urandom);
    step(E_T2, 1'b1);
    opcode = op;
    if (op != BR_OP) begin
      step(16'h0, 1'b1);
      exp_ill = 1'b1;
      return;
    end
    step(E_T3, 1'b1);
    opcode = 5'($urandom); con = 1'($urandom); run = drop_t2 ? 1'b0 : 1'($urandom);
    if (clr_t4) begin
      do_clr();
      return;
    end
    step(E_T4, 1'b1);
    con = 1'($urandom);
    step(E_T5, 1'b1);
    con = c; run = run_t6;
    step(E_T6 | (c ? E_PCIN : 16'h0), 1'b1);
    m_cnt = (m_cnt + 1) & CMASK;
    if (c) m_tk = (m_tk + 1) & CMASK;
  endtask

  task automatic start_from_idle();
    run = 1'b1;
    step(16'h0, 1'b0);
  endtask

  initial begin
    bit in_idle;
    logic [31:0] ra;
    bit rt6;
    clr = 1'b1; run = 1'b0; mem_ready = 1'b0; con = 1'b0; opcode = 5'd0;
    m_cnt = 0; m_tk = 0; exp_ill = 1'b0; exp_str = '0; exp_busy = 1'b0;
    clear_stats();
    @(posedge clk); #1;
    run = 1'b1;
    step(16'h0, 1'b0);               // run ignored while clr held
    step(16'h0, 1'b0);
    clr = 1'b0; run = 1'b0;
    step(16'h0, 1'b0);

    // taken brzr, minimum timing
    start_from_idle(); clear_stats();
    do_instr(0, BR_OP, 32'd0, 2'b00, 1'b0, 1'b0, 1'b0);
    chk("min_busy_cycles", busy_cycles, 7);
    chk("taken_pcin_pulses", pcin_cycles, 2);
    chk("lit_count1", br_count, 1);
    chk("lit_taken1", br_taken, 1);

    // not-taken brpl
    run = 1'b0; step(16'h0, 1'b0);
    start_from_idle(); clear_stats();
    do_instr(0, BR_OP, 32'h8000_0000, 2'b10, 1'b0, 1'b0, 1'b0);
    chk("nt_pcin_pulses", pcin_cycles, 1);
    chk("lit_count2", br_count, 2);
    chk("lit_taken2", br_taken, 1);

    // three memory wait states, taken brmi
    start_from_idle(); clear_stats();
    do_instr(3, BR_OP, 32'hF000_0001, 2'b11, 1'b0, 1'b0, 1'b0);
    chk("wait_busy_cycles", busy_cycles, 10);
    chk("wait_read_cycles", read_cycles, 4);
    chk("lit_count3", br_count, 3);

    // async clear in the middle of T4
    start_from_idle();
    do_instr(1, BR_OP, 32'd5, 2'b01, 1'b0, 1'b0, 1'b1);
    chk("clr_count", br_count, 0);
    chk("clr_taken", br_taken, 0);
    run = 1'b0; step(16'h0, 1'b0);

    // randomized mix of legal branches
    in_idle = 1'b1;
    for (int n = 0; n < 24; n++) begin
      if (in_idle) begin
        for (int k = 0; k < int'($urandom_range(0, 2)); k++) begin
          run = 1'b0; step(16'h0, 1'b0);
        end
        start_from_idle();
      end
      ra = $urandom;
      if ($urandom_range(0, 3) == 0) ra = 32'd0;
      rt6 = 1'($urandom);
      do_instr(int'($urandom_range(0, 3)), BR_OP, ra, 2'($urandom), rt6, 1'b0, 1'b0);
      in_idle = !rt6;
    end
    if (!in_idle) begin
      run = 1'b0;
      // the last T6 had run=1, so one more instruction drains to IDLE
      do_instr(0, BR_OP, 32'd0, 2'b00, 1'b0, 1'b0, 1'b0);
    end
    run = 1'b0; step(16'h0, 1'b0);

    // 16 taken brnz: counters wrap; run dropped in T2 of the last one
    do_clr();
    start_from_idle();
    for (int n = 0; n < 16; n++)
      do_instr(0, BR_OP, 32'd1, 2'b01, n != 15, n == 15, 1'b0);
    chk("wrap_count", br_count, 0);
    chk("wrap_taken", br_taken, 0);
    run = 1'b0; step(16'h0, 1'b0);
    step(16'h0, 1'b0);

    // illegal opcode: HALT until clr
    start_from_idle();
    do_instr(0, 5'b00011, 32'd0, 2'b00, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 6; k++) begin
      run = 1'($urandom); mem_ready = 1'($urandom); opcode = BR_OP;
      step(16'h0, 1'b0);
    end
    chk("lit_illegal", illegal, 1);
    chk("halt_busy", busy, 0);
    do_clr();
    chk("illegal_cleared", illegal, 0);
    run = 1'b0; step(16'h0, 1'b0);
    start_from_idle();
    do_instr(2, BR_OP, 32'd0, 2'b00, 1'b0, 1'b0, 1'b0);
    chk("recover_count", br_count, 1);
    run = 1'b0; step(16'h0, 1'b0);

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
